// File: rtl/vga_pkg.sv
// Shared pixel types and helpers for the video output path.
// Colour formats, background modes and sync polarity.
package vga_pkg;

    localparam bit SYNC_ACTIVE_LOW = 1'b1;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } rgb555_t;

    typedef enum logic [1:0] {
        BG_SOLID    = 2'd0,
        BG_CHECKER  = 2'd1,
        BG_GRADIENT = 2'd2,
        BG_BLACK    = 2'd3
    } bg_mode_e;

    function automatic logic [7:0] expand5to8(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Video and sprite-control bundle between vga_controller, the
// sprite register file and the compositor.
interface sprite_compositor_if #(
    parameter int NUM_SPRITES = 4,
    parameter int COL_W       = 12,
    parameter int ROW_W       = 11
);
    logic [COL_W-1:0]             display_col;
    logic [ROW_W-1:0]             display_row;
    logic                         visible;
    logic                         hsync;
    logic                         vsync;
    logic [NUM_SPRITES*COL_W-1:0] sprite_x;
    logic [NUM_SPRITES*ROW_W-1:0] sprite_y;
    logic [NUM_SPRITES*15-1:0]    sprite_color;
    logic [NUM_SPRITES-1:0]       sprite_enable;
    logic [1:0]                   bg_mode;
    logic [8:0]                   bg_tint;
    logic                         update_req;
    logic                         update_ack;
    logic [7:0]                   red;
    logic [7:0]                   green;
    logic [7:0]                   blue;
    logic                         hs_out;
    logic                         vs_out;
    logic                         blank_n_out;
    logic [NUM_SPRITES-1:0]       collision_mask;
    logic                         collision_valid;

    modport master (
        output display_col, display_row, visible, hsync, vsync,
        output sprite_x, sprite_y, sprite_color, sprite_enable,
        output bg_mode, bg_tint, update_req,
        input  update_ack, red, green, blue,
        input  hs_out, vs_out, blank_n_out,
        input  collision_mask, collision_valid
    );

    modport slave (
        input  display_col, display_row, visible, hsync, vsync,
        input  sprite_x, sprite_y, sprite_color, sprite_enable,
        input  bg_mode, bg_tint, update_req,
        output update_ack, red, green, blue,
        output hs_out, vs_out, blank_n_out,
        output collision_mask, collision_valid
    );

endinterface

// File: rtl/sprite_hit.sv
// Registered bounds test for one square sprite; the end coordinate
// carries an extra bit so sprites near the field edge never wrap.
module sprite_hit #(
    parameter int SPRITE_SIZE = 32,
    parameter int COL_W       = 12,
    parameter int ROW_W       = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [COL_W-1:0] i_col,
    input  logic [ROW_W-1:0] i_row,
    input  logic [COL_W-1:0] i_x,
    input  logic [ROW_W-1:0] i_y,
    input  logic             i_en,
    output logic             o_hit
);

    localparam logic [COL_W:0] X_SPAN = (COL_W+1)'(SPRITE_SIZE - 1);
    localparam logic [ROW_W:0] Y_SPAN = (ROW_W+1)'(SPRITE_SIZE - 1);

    logic [COL_W:0] w_x_end;
    logic [ROW_W:0] w_y_end;
    logic           w_in_x;
    logic           w_in_y;
    logic           r_hit;

    assign w_x_end = {1'b0, i_x} + X_SPAN;
    assign w_y_end = {1'b0, i_y} + Y_SPAN;
    assign w_in_x  = (i_col >= i_x) && ({1'b0, i_col} <= w_x_end);
    assign w_in_y  = (i_row >= i_y) && ({1'b0, i_row} <= w_y_end);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= i_en && w_in_x && w_in_y;
        end
    end

    assign o_hit = r_hit;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite/background compositor with frame-atomic
// register updates and per-frame collision reporting.
module sprite_compositor
    import vga_pkg::*;
#(
    parameter int NUM_SPRITES   = 4,
    parameter int SPRITE_SIZE   = 32,
    parameter int COL_W         = 12,
    parameter int ROW_W         = 11,
    parameter int CHECKER_SHIFT = 7
) (
    input logic                clock,
    input logic                reset,
    sprite_compositor_if.slave bus
);

    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    typedef struct packed {
        logic [NUM_SPRITES-1:0][COL_W-1:0] x;
        logic [NUM_SPRITES-1:0][ROW_W-1:0] y;
        logic [NUM_SPRITES-1:0][14:0]      color;
        logic [NUM_SPRITES-1:0]            en;
        bg_mode_e                          mode;
        logic [8:0]                        tint;
    } cfg_t;

    cfg_t w_cfg_in;
    cfg_t r_staging;
    cfg_t r_active;

    logic r_pending;
    logic r_vs_prev;
    logic r_ack;
    logic w_boundary;
    logic w_capture;

    logic [NUM_SPRITES-1:0] w_hit;
    logic [NUM_SPRITES-1:0] r_acc;
    logic [NUM_SPRITES-1:0] r_mask;
    logic                   r_cv;
    logic                   w_multi;

    logic       r_s1_vis;
    logic       r_s1_chk;
    logic [4:0] r_s1_grad;
    logic       r_s1_hs;
    logic       r_s1_vs;

    logic        w_any;
    rgb555_t     w_sel;
    logic [8:0]  w_tint;
    logic [4:0]  w_lo;
    logic [23:0] w_pix;
    logic [23:0] r_pix;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;

    always_comb begin
        w_cfg_in       = '0;
        w_cfg_in.x     = bus.sprite_x;
        w_cfg_in.y     = bus.sprite_y;
        w_cfg_in.color = bus.sprite_color;
        w_cfg_in.en    = bus.sprite_enable;
        w_cfg_in.mode  = bg_mode_e'(bus.bg_mode);
        w_cfg_in.tint  = bus.bg_tint;
    end

    assign w_boundary = bus.vsync && !r_vs_prev;
    assign w_capture  = bus.update_req && !r_pending;

    // Capture needs pending low, promotion needs it high, so a
    // request landing on the boundary waits one full frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vs_prev     <= SYNC_IDLE;
            r_pending     <= 1'b0;
            r_ack         <= 1'b0;
            r_staging     <= '0;
            r_active      <= '0;
            r_active.mode <= BG_BLACK;
        end else begin
            r_vs_prev <= bus.vsync;
            r_ack     <= w_boundary && r_pending;
            if (w_capture) begin
                r_staging <= w_cfg_in;
                r_pending <= 1'b1;
            end else if (w_boundary && r_pending) begin
                r_active  <= r_staging;
                r_pending <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(
            .SPRITE_SIZE (SPRITE_SIZE),
            .COL_W       (COL_W),
            .ROW_W       (ROW_W)
        ) u_hit (
            .clock (clock),
            .reset (reset),
            .i_col (bus.display_col),
            .i_row (bus.display_row),
            .i_x   (r_active.x[g]),
            .i_y   (r_active.y[g]),
            .i_en  (r_active.en[g]),
            .o_hit (w_hit[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_vis  <= 1'b0;
            r_s1_chk  <= 1'b0;
            r_s1_grad <= '0;
            r_s1_hs   <= SYNC_IDLE;
            r_s1_vs   <= SYNC_IDLE;
        end else begin
            r_s1_vis  <= bus.visible;
            r_s1_chk  <= bus.display_row[CHECKER_SHIFT]
                       ^ bus.display_col[CHECKER_SHIFT];
            r_s1_grad <= bus.display_col[CHECKER_SHIFT-1 -: 5];
            r_s1_hs   <= bus.hsync;
            r_s1_vs   <= bus.vsync;
        end
    end

    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_tint = r_active.tint;
        w_lo   = '0;
        w_pix  = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any = 1'b1;
                w_sel = rgb555_t'(r_active.color[i]);
            end
        end
        unique case (r_active.mode)
            BG_SOLID:    w_lo = '0;
            BG_CHECKER:  w_lo = {5{r_s1_chk}};
            BG_GRADIENT: w_lo = r_s1_grad;
            BG_BLACK:    w_tint = '0;
        endcase
        if (!r_s1_vis) begin
            w_pix = '0;
        end else if (w_any) begin
            w_pix = {expand5to8(w_sel.r),
                     expand5to8(w_sel.g),
                     expand5to8(w_sel.b)};
        end else begin
            w_pix = {w_tint[8:6], w_lo,
                     w_tint[5:3], w_lo,
                     w_tint[2:0], w_lo};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pix     <= '0;
            r_hs      <= SYNC_IDLE;
            r_vs      <= SYNC_IDLE;
            r_blank_n <= 1'b0;
        end else begin
            r_pix     <= w_pix;
            r_hs      <= r_s1_hs;
            r_vs      <= r_s1_vs;
            r_blank_n <= r_s1_hs & r_s1_vs;
        end
    end

    assign w_multi = |(w_hit & (w_hit - 1'b1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc  <= '0;
            r_mask <= '0;
            r_cv   <= 1'b0;
        end else begin
            r_cv <= w_boundary;
            if (w_boundary) begin
                r_mask <= r_acc;
                r_acc  <= '0;
            end else if (r_s1_vis && w_multi) begin
                r_acc <= r_acc | w_hit;
            end
        end
    end

    assign bus.red             = r_pix[23:16];
    assign bus.green           = r_pix[15:8];
    assign bus.blue            = r_pix[7:0];
    assign bus.hs_out          = r_hs;
    assign bus.vs_out          = r_vs;
    assign bus.blank_n_out     = r_blank_n;
    assign bus.update_ack      = r_ack;
    assign bus.collision_mask  = r_mask;
    assign bus.collision_valid = r_cv;

endmodule
